// File: rtl/instr_sequencer.sv
// Instruction sequencer: fetches 16-bit words, steps each through a 4-cycle
// execute sequence, and reports HALT / illegal-opcode status to the control unit.
//
// state  | meaning
// IDLE   | waiting for run
// FETCH  | instr_ready follows run, waiting for a valid word
// EXEC   | stepping 00..11 through the latched instruction
// HALTED | HALT opcode seen, parked until run drops
module instr_sequencer (
    input  logic        clock,
    input  logic        resetn,
    input  logic        run,
    input  logic        hold,
    input  logic        instr_valid,
    input  logic [15:0] instr_data,
    output logic        instr_ready,
    output logic [15:0] instruction,
    output logic [1:0]  current_state,
    output logic        busy,
    output logic        done,
    output logic        illegal,
    output logic [7:0]  instr_count
);

    localparam logic [2:0] OP_ILLEGAL = 3'b011;
    localparam logic [2:0] OP_HALT    = 3'b110;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        EXEC   = 2'd2,
        HALTED = 2'd3
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [1:0] step;
    logic       accept;
    logic       retire;
    logic       is_halt;
    logic       is_illegal;

    assign is_halt    = (instr_data[15:13] == OP_HALT);
    assign is_illegal = (instr_data[15:13] == OP_ILLEGAL);

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        instr_ready   = 1'b0;
        busy          = 1'b0;
        current_state = 2'b00;
        accept        = 1'b0;
        retire        = 1'b0;
        case (state)
            IDLE: begin
                if (run) begin
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                busy        = 1'b1;
                instr_ready = run;
                if (!run) begin
                    state_nxt = IDLE;
                end else if (instr_valid) begin
                    accept    = 1'b1;
                    state_nxt = is_halt ? HALTED : EXEC;
                end
            end
            EXEC: begin
                busy          = 1'b1;
                current_state = step;
                // run is only consulted at the final step; earlier drops never abort
                if (!hold && step == 2'b11) begin
                    retire    = 1'b1;
                    state_nxt = run ? FETCH : IDLE;
                end
            end
            HALTED: begin
                if (!run) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            instruction <= 16'h0000;
            step        <= 2'b00;
            instr_count <= 8'h00;
            illegal     <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= accept && is_halt;
            if (state == IDLE && run) begin
                illegal <= 1'b0;
            end
            if (accept) begin
                instruction <= instr_data;
                step        <= 2'b00;
                if (is_illegal) begin
                    illegal <= 1'b1;
                end
            end
            if (state == EXEC && !hold) begin
                step <= step + 2'd1;
            end
            if (retire) begin
                instr_count <= instr_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: directed scenarios plus random traffic, every cycle
// compared against a phase/step reference model of the sequencer rules.
module tb_instr_sequencer;

    logic        clock = 1'b0;
    logic        resetn;
    logic        run;
    logic        hold;
    logic        instr_valid;
    logic [15:0] instr_data;
    logic        instr_ready;
    logic [15:0] instruction;
    logic [1:0]  current_state;
    logic        busy;
    logic        done;
    logic        illegal;
    logic [7:0]  instr_count;

    instr_sequencer dut (
        .clock         (clock),
        .resetn        (resetn),
        .run           (run),
        .hold          (hold),
        .instr_valid   (instr_valid),
        .instr_data    (instr_data),
        .instr_ready   (instr_ready),
        .instruction   (instruction),
        .current_state (current_state),
        .busy          (busy),
        .done          (done),
        .illegal       (illegal),
        .instr_count   (instr_count)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: phase 0 idle, 1 fetch, 2 exec, 3 halted
    int          m_phase;
    int          m_step;
    logic [15:0] m_ir;
    int          m_count;
    bit          m_illegal;
    bit          m_done;

    logic [15:0] word_q[$];
    int          done_seen;
    int          cs1_seen;

    task automatic check_eq(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic model_update();
        bit accepted;
        accepted = 0;
        if (!resetn) begin
            m_phase = 0; m_step = 0; m_ir = 16'h0; m_count = 0; m_illegal = 0; m_done = 0;
        end else begin
            m_done = 0;
            case (m_phase)
                0: if (run) begin m_phase = 1; m_illegal = 0; end
                1: begin
                    if (!run) m_phase = 0;
                    else if (instr_valid) begin
                        accepted = 1;
                        m_ir = instr_data;
                        if (instr_data[15:13] == 3'd6) begin
                            m_phase = 3; m_done = 1;
                        end else begin
                            m_phase = 2; m_step = 0;
                            if (instr_data[15:13] == 3'd3) m_illegal = 1;
                        end
                    end
                end
                2: if (!hold) begin
                    if (m_step == 3) begin
                        m_count = (m_count + 1) % 256;
                        m_phase = run ? 1 : 0;
                    end else begin
                        m_step = m_step + 1;
                    end
                end
                default: if (!run) m_phase = 0;
            endcase
        end
        if (accepted && word_q.size() > 0) void'(word_q.pop_front());
    endtask

    // entered just after a falling edge with inputs already driven
    task automatic cycle();
        #1;
        check_eq("instr_ready", 16'(instr_ready), 16'(m_phase == 1 && run));
        check_eq("busy", 16'(busy), 16'(m_phase == 1 || m_phase == 2));
        check_eq("current_state", 16'(current_state), (m_phase == 2) ? 16'(m_step) : 16'h0);
        check_eq("done", 16'(done), 16'(m_done));
        check_eq("illegal", 16'(illegal), 16'(m_illegal));
        check_eq("instr_count", 16'(instr_count), 16'(m_count));
        check_eq("instruction", instruction, m_ir);
        if (done === 1'b1) done_seen++;
        if (current_state === 2'b01) cs1_seen++;
        @(posedge clock);
        model_update();
        @(negedge clock);
    endtask

    task automatic drive_q();
        instr_valid = (word_q.size() > 0);
        instr_data  = (word_q.size() > 0) ? word_q[0] : 16'h0000;
    endtask

    task automatic run_n(input int n);
        repeat (n) begin
            drive_q();
            cycle();
        end
    endtask

    task automatic run_until_step(input int s, input int limit);
        int k = 0;
        while (!(m_phase == 2 && m_step == s) && k < limit) begin
            drive_q();
            cycle();
            k++;
        end
        check_eq("reach_step", 16'(current_state), 16'(s));
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        run    = 1'b0;
        hold   = 1'b0;
        word_q.delete();
        run_n(2);
        resetn    = 1'b1;
        done_seen = 0;
        cs1_seen  = 0;
    endtask

    initial begin
        resetn = 1'b0; run = 1'b0; hold = 1'b0; instr_valid = 1'b0; instr_data = 16'h0;
        @(posedge clock);
        model_update();
        @(negedge clock);

        // single SUB word
        do_reset();
        run = 1'b1;
        word_q.push_back(16'h2480);
        run_n(7);
        check_eq("sub_count", 16'(instr_count), 16'd1);
        check_eq("sub_ir", instruction, 16'h2480);
        check_eq("sub_ready", 16'(instr_ready), 16'd1);

        // three back-to-back words
        do_reset();
        run = 1'b1;
        word_q.push_back(16'h0011);
        word_q.push_back(16'h4022);
        word_q.push_back(16'hA033);
        run_n(17);
        check_eq("b2b_count", 16'(instr_count), 16'd3);
        check_eq("b2b_ir", instruction, 16'hA033);

        // hold at step 01 for three cycles
        do_reset();
        run = 1'b1;
        word_q.push_back(16'h0042);
        run_until_step(1, 10);
        cs1_seen = 0;
        hold = 1'b1;
        run_n(3);
        hold = 1'b0;
        run_n(6);
        check_eq("hold_cs1_cycles", 16'(cs1_seen), 16'd4);
        check_eq("hold_count", 16'(instr_count), 16'd1);

        // ADD then HALT
        do_reset();
        run = 1'b1;
        word_q.push_back(16'h0005);
        word_q.push_back(16'hC000);
        run_n(12);
        check_eq("halt_done_pulses", 16'(done_seen), 16'd1);
        check_eq("halt_count", 16'(instr_count), 16'd1);
        check_eq("halt_busy", 16'(busy), 16'd0);
        run = 1'b0;
        run_n(3);

        // illegal opcode, sticky until next IDLE->FETCH
        do_reset();
        run = 1'b1;
        word_q.push_back(16'h6000);
        run_n(8);
        check_eq("ill_set", 16'(illegal), 16'd1);
        check_eq("ill_count", 16'(instr_count), 16'd1);
        run = 1'b0;
        run_n(3);
        check_eq("ill_sticky", 16'(illegal), 16'd1);
        run = 1'b1;
        run_n(2);
        check_eq("ill_clear", 16'(illegal), 16'd0);

        // counter wrap 255 -> 0
        do_reset();
        run = 1'b1;
        for (int i = 0; i < 255; i++) word_q.push_back(16'(i & 16'h1FFF));
        run_n(2 + 255 * 5);
        check_eq("count_255", 16'(instr_count), 16'd255);
        word_q.push_back(16'h0001);
        run_n(6);
        check_eq("count_wrap", 16'(instr_count), 16'd0);

        // reset mid-EXEC at step 10
        do_reset();
        run = 1'b1;
        word_q.push_back(16'h1234);
        run_until_step(2, 10);
        resetn = 1'b0;
        run_n(1);
        check_eq("rst_ir", instruction, 16'h0000);
        check_eq("rst_busy", 16'(busy), 16'd0);
        resetn = 1'b1;

        // run dropped at step 01 still completes the instruction
        word_q.push_back(16'h4321);
        run_until_step(1, 10);
        run = 1'b0;
        run_n(6);
        check_eq("rundrop_count", 16'(instr_count), 16'd1);
        check_eq("rundrop_busy", 16'(busy), 16'd0);

        // random traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            resetn      = ($urandom % 200) != 0;
            run         = ($urandom % 8) != 0;
            hold        = ($urandom % 4) == 0;
            instr_valid = $urandom % 2;
            instr_data  = 16'($urandom);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
